// File: rtl/gf_digit_serial_mult_pkg.sv
// Shared types and sizing helpers for the digit-serial GF(2)[x] multiplier.
package gf_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cyc_of(input int n, input int digits);
        return n / digits;
    endfunction

    // A counter always needs at least one bit, even for single-cycle operation.
    function automatic int cnt_width(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/gf_digit_serial_mult_step.sv
// One clock's worth of Horner iteration: DIGITS chained mulx-reduce-add stages.
module gf_digit_step #(
    parameter int          d      = 0,
    parameter logic [8+d:0] PQ    = 9'h11B,
    parameter int          DIGITS = 1
) (
    input  logic [7+d:0]        acc,
    input  logic [7+d:0]        a_reg,
    input  logic [DIGITS-1:0]   b_top,
    output logic [7+d:0]        acc_next
);

    localparam int N = 8 + d;

    logic [DIGITS:0][N-1:0] chain;

    assign chain[0] = acc;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_stage
            logic [N-1:0] shifted;
            // The x^N term folds back through the low N coefficients of PQ.
            assign shifted      = {chain[k][N-2:0], 1'b0} ^ ({N{chain[k][N-1]}} & PQ[N-1:0]);
            assign chain[k+1]   = shifted ^ ({N{b_top[DIGITS-1-k]}} & a_reg);
        end
    endgenerate

    assign acc_next = chain[DIGITS];

endmodule

// File: rtl/gf_digit_serial_mult.sv
// Digit-serial P = A*B mod PQ over GF(2)[x], DIGITS bits of B per clock, valid/ready on both sides.
module gf_digit_serial_mult
    import gf_mult_pkg::*;
#(
    parameter int           d      = 0,
    parameter logic [8+d:0] PQ     = 9'h11B,
    parameter int           DIGITS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7+d:0]  a,
    input  logic [7+d:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7+d:0]  p
);

    localparam int N   = 8 + d;
    localparam int CYC = cyc_of(N, DIGITS);
    localparam int CW  = cnt_width(CYC);

    generate
        if ((N % DIGITS) != 0) begin : g_bad_digits
            $error("DIGITS must divide the field width");
        end
        if (PQ[N] != 1'b1) begin : g_bad_pq
            $error("PQ must be monic of degree N");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;

    logic [N-1:0]    acc_step;
    logic            accept;
    logic            last;

    gf_digit_step #(
        .d      (d),
        .PQ     (PQ),
        .DIGITS (DIGITS)
    ) u_step (
        .acc      (acc_q),
        .a_reg    (a_q),
        .b_top    (b_q[N-1 -: DIGITS]),
        .acc_next (acc_step)
    );

    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == CW'(CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: operands are captured only on accept, so a/b may change freely afterwards.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        if (state_q == DONE && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            acc_d = acc_step;
            b_d   = b_q << DIGITS;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                p_d         = acc_step;
                out_valid_d = 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_gf_digit_serial_mult.sv
// Directed and model-checked bench for gf_digit_serial_mult at DIGITS=1/2/4 (d=0) and d=2.
module tb_gf_digit_serial_mult;

    localparam logic [10:0] PQ2 = 11'b100_1101_0111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [2:0] ir, ov;
    logic [7:0] pp [3];

    logic       in_valid2 = 1'b0;
    logic       out_ready2 = 1'b0;
    logic [9:0] a2 = '0, b2 = '0;
    logic       ir2, ov2;
    logic [9:0] p2;

    int exp_lat [3] = '{9, 5, 3};

    gf_digit_serial_mult #(.d(0), .PQ(9'h11B), .DIGITS(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
        .out_valid(ov[0]), .out_ready(out_ready), .p(pp[0]));
    gf_digit_serial_mult #(.d(0), .PQ(9'h11B), .DIGITS(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
        .out_valid(ov[1]), .out_ready(out_ready), .p(pp[1]));
    gf_digit_serial_mult #(.d(0), .PQ(9'h11B), .DIGITS(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
        .out_valid(ov[2]), .out_ready(out_ready), .p(pp[2]));
    gf_digit_serial_mult #(.d(2), .PQ(PQ2), .DIGITS(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(out_ready2), .p(p2));

    // Schoolbook carry-less product followed by top-down reduction.
    function automatic logic [9:0] ref_mul(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] prod;
        prod = '0;
        for (int i = 0; i < 10; i++)
            if (y[i]) prod = prod ^ (19'(x) << i);
        for (int i = 18; i >= 10; i--)
            if (prod[i]) prod = prod ^ (19'(PQ2) << (i - 10));
        return prod[9:0];
    endfunction

    task automatic start_op(input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1;
        #1;
        checks++;
        if (ir !== 3'b111) begin
            failures++;
            $display("FAIL start_in_ready got=%b want=111", ir);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h3C;
    endtask

    task automatic wait_results(input logic [7:0] exp, input string nm);
        int lat [3];
        int n;
        lat = '{0, 0, 0};
        n = 1;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
            for (int k = 0; k < 3; k++)
                if (ov[k] === 1'b1 && lat[k] == 0) lat[k] = n;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lat[k] != exp_lat[k]) begin
                failures++;
                $display("FAIL %s_latency inst=%0d got=%0d want=%0d", nm, k, lat[k], exp_lat[k]);
            end
            checks++;
            if (pp[k] !== exp) begin
                failures++;
                $display("FAIL %s_product inst=%0d got=%h want=%h", nm, k, pp[k], exp);
            end
        end
    endtask

    task automatic drain(input logic [7:0] exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (ov !== 3'b000 || pp[0] !== exp || pp[1] !== exp || pp[2] !== exp) begin
            failures++;
            $display("FAIL drain got ov=%b p=%h/%h/%h want ov=000 p=%h", ov, pp[0], pp[1], pp[2], exp);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ov !== 3'b000 || pp[0] !== 8'h00 || pp[1] !== 8'h00 || pp[2] !== 8'h00 || ov2 !== 1'b0 || p2 !== 10'h000) begin
            failures++;
            $display("FAIL reset_outputs got ov=%b p=%h/%h/%h ov2=%b p2=%h want zeros", ov, pp[0], pp[1], pp[2], ov2, p2);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ir !== 3'b111 || ir2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b/%b want=111/1", ir, ir2);
        end
    endtask

    task automatic test_products();
        logic [7:0] va [5] = '{8'h57, 8'h80, 8'h57, 8'h00, 8'h01};
        logic [7:0] vb [5] = '{8'h83, 8'h02, 8'h13, 8'hFF, 8'h5A};
        logic [7:0] vp [5] = '{8'hC1, 8'h1B, 8'hFE, 8'h00, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i]);
            wait_results(vp[i], $sformatf("vec%0d", i));
            drain(vp[i]);
        end
    endtask

    task automatic test_back_to_back();
        start_op(8'h57, 8'h13);
        wait_results(8'hFE, "bp_first");
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ov !== 3'b111 || ir !== 3'b000 || pp[0] !== 8'hFE || pp[1] !== 8'hFE || pp[2] !== 8'hFE) begin
                failures++;
                $display("FAIL backpressure cyc=%0d got ov=%b ir=%b p=%h/%h/%h want ov=111 ir=000 p=fe",
                         c, ov, ir, pp[0], pp[1], pp[2]);
            end
        end
        @(negedge clk);
        a = 8'h80; b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (ir !== 3'b111) begin
            failures++;
            $display("FAIL b2b_in_ready got=%b want=111", ir);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        a = 8'hFF; b = 8'hFF;
        wait_results(8'h1B, "b2b_second");
        drain(8'h1B);
    endtask

    task automatic test_reset_mid_busy();
        start_op(8'h57, 8'h83);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov !== 3'b100) begin
            failures++;
            $display("FAIL pre_reset_ov got=%b want=100", ov);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov !== 3'b000 || pp[0] !== 8'h00 || pp[1] !== 8'h00 || pp[2] !== 8'h00 || ir !== 3'b111) begin
            failures++;
            $display("FAIL mid_reset got ov=%b ir=%b p=%h/%h/%h want ov=000 ir=111 p=00",
                     ov, ir, pp[0], pp[1], pp[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h57, 8'h83);
        wait_results(8'hC1, "post_reset");
        drain(8'hC1);
    endtask

    task automatic test_redundant_random();
        logic [9:0] exp;
        int n;
        int bad_lat;
        bad_lat = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a2 = 10'($urandom);
            b2 = 10'($urandom);
            if (i < 8) begin
                a2 = a2 | 10'h300;
                b2 = b2 | 10'h200;
            end
            exp = ref_mul(a2, b2);
            in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            a2 = ~a2; b2 = ~b2;
            n = 0;
            while (ov2 !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (p2 !== exp || n != 5) begin
                failures++;
                $display("FAIL redundant iter=%0d got p=%h lat=%0d want p=%h lat=5", i, p2, n, exp);
            end
            @(negedge clk);
            out_ready2 = 1'b1;
            @(posedge clk); #1;
            out_ready2 = 1'b0;
            if (ov2 !== 1'b0) bad_lat++;
        end
        checks++;
        if (bad_lat != 0) begin
            failures++;
            $display("FAIL redundant_drain got=%0d stuck want=0", bad_lat);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_back_to_back();
        test_reset_mid_busy();
        test_redundant_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
